// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: producer end of the core's instruction interface.
// Keeps the fetch PC, issues one-at-a-time req/ack reads to instruction memory,
// buffers returned words in a small FIFO and hands them downstream with
// valid/ready. Branch/jump redirects flush the FIFO and any in-flight fetch.
//
// Ports:
//   clk, reset                      system clock, synchronous active-high reset
//   imem_req, imem_addr             fetch request and word-aligned address
//   imem_ack, imem_rdata            memory response and returned word
//   redirect_valid, redirect_target taken branch/jump and its new PC
//   instr_valid, instr_ready        downstream handshake
//   instruction, instr_pc           instruction word (NOP when empty) and its PC
//
// State table:
//   IDLE  | no request outstanding; waiting for FIFO space
//   REQ   | request at fetch_pc outstanding; address held until ack
//   FLUSH | stale request outstanding; its ack is discarded
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int unsigned     PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       pc_mem   [FIFO_DEPTH];
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_after_pop;
  logic [31:0]       last_pc_q;
  logic [31:0]       target;
  logic              ack, pop, push;

  // Low two bits of the target are discarded by the mask.
  assign target = redirect_target & 32'hFFFF_FFFC;
  // An ack with no request outstanding is meaningless and ignored.
  assign ack    = imem_ack && imem_req;
  assign pop    = instr_valid && instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  // Next state. Invariant: in REQ, addr_q == fetch_pc_q. Credit rule: a new
  // request is issued only if the FIFO, after this cycle's push/pop, has room
  // for its data.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    addr_d          = addr_q;
    push            = 1'b0;
    count_after_pop = count_q - CNT_W'(pop);
    if (redirect_valid) begin
      fetch_pc_d = target;
      unique case (state_q)
        IDLE: begin
          state_d = REQ;
          addr_d  = target;
        end
        REQ: begin
          if (ack) begin
            state_d = REQ;
            addr_d  = target;
          end else begin
            state_d = FLUSH;
          end
        end
        FLUSH: state_d = ack ? IDLE : FLUSH;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_after_pop < DEPTH_C) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        REQ: begin
          if (ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (count_after_pop + CNT_W'(1) < DEPTH_C) begin
              addr_d = fetch_pc_q + 32'd4;
            end else begin
              state_d = IDLE;
            end
          end
        end
        FLUSH: begin
          if (ack) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs. No bypass: data is only visible once it sits in the FIFO.
  always_comb begin
    imem_req    = (state_q == REQ) || (state_q == FLUSH);
    imem_addr   = addr_q;
    instr_valid = (count_q != '0);
    instruction = NOP;
    instr_pc    = last_pc_q;
    if (count_q != '0) begin
      instruction = data_mem[rd_ptr_q];
      instr_pc    = pc_mem[rd_ptr_q];
    end
  end

  // FIFO control. A redirect empties it; a pop in that cycle is simply lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      if (count_q != '0) last_pc_q <= pc_mem[rd_ptr_q];
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage (no reset needed; guarded by count_q).
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      data_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  // The credit rule makes overflow unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push && !pop) begin
      assert (count_q < DEPTH_C);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a variable-latency memory responder, a
// stream scoreboard (expected PC sequence restarted at every redirect/reset)
// and directed plus randomized scenario tasks.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  int vectors     = 0;
  int miscompares = 0;
  int ack_count   = 0;
  int pop_count   = 0;

  // responder controls
  int lat_min   = 0;
  int lat_max   = 0;
  int wait_cnt  = 0;
  int cur_lat   = 0;
  bit noise_en  = 1'b0;
  bit force_ack = 1'b0;

  // scoreboard state
  logic [31:0] exp_pc;
  logic [31:0] last_pc;
  logic [31:0] prev_addr;
  bit          prev_hold;
  bit          prev_redir;

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Memory: acks after cur_lat waiting cycles (0 = same cycle req rises).
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        wait_cnt   = 0;
        cur_lat    = $urandom_range(lat_max, lat_min);
      end else if (imem_req) begin
        if (wait_cnt >= cur_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
          cur_lat    = $urandom_range(lat_max, lat_min);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        wait_cnt   = 0;
        cur_lat    = $urandom_range(lat_max, lat_min);
        imem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = $urandom;
      end
    end
  end

  // Stream scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      exp_pc     = RST_PC;
      last_pc    = '0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (instr_valid) begin
        if (instr_ready) begin
          vectors++;
          if (instr_pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
            miscompares++;
            $display("FAIL stream: got pc=%h instr=%h, expected pc=%h instr=%h",
                     instr_pc, instruction, exp_pc, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
          pop_count++;
        end
        last_pc = instr_pc;
      end else begin
        vectors++;
        if (instruction !== NOP || instr_pc !== last_pc) begin
          miscompares++;
          $display("FAIL empty_output: got instr=%h pc=%h, expected instr=%h pc=%h",
                   instruction, instr_pc, NOP, last_pc);
        end
      end
      if (prev_hold) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          miscompares++;
          $display("FAIL addr_hold: got req=%b addr=%h, expected req=1 addr=%h",
                   imem_req, imem_addr, prev_addr);
        end
      end
      if (prev_redir) begin
        vectors++;
        if (instr_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL redirect_clear: got valid=%b, expected 0", instr_valid);
        end
      end
      if (imem_req && imem_ack) ack_count++;
      if (redirect_valid) exp_pc = {redirect_target[31:2], 2'b00};
      prev_hold  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      prev_redir = redirect_valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    lat_min = 0; lat_max = 0; noise_en = 1'b0; instr_ready = 1'b1;
    reset = 1'b1;
    cyc(2);
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL reset_req: got req=%b addr=%h, expected req=0 addr=%h", imem_req, imem_addr, RST_PC);
    end
    vectors++;
    if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instruction !== NOP) begin
      miscompares++;
      $display("FAIL reset_out: got valid=%b pc=%h instr=%h, expected 0 0 %h",
               instr_valid, instr_pc, instruction, NOP);
    end
    reset = 1'b0;
    cyc(1);
    vectors++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL first_req: got valid=%b req=%b addr=%h, expected 0 1 %h",
               instr_valid, imem_req, imem_addr, RST_PC);
    end
    cyc(1);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== RST_PC) begin
      miscompares++;
      $display("FAIL first_valid: got valid=%b pc=%h, expected 1 %h", instr_valid, instr_pc, RST_PC);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (instr_valid) n++;
    end
    vectors++;
    if (n != 20) begin
      miscompares++;
      $display("FAIL sustained: got %0d valid cycles, expected 20", n);
    end
  endtask

  task automatic test_latency();
    int a0, p0;
    lat_min = 3; lat_max = 3; instr_ready = 1'b1;
    apply_reset();
    a0 = ack_count; p0 = pop_count;
    cyc(40);
    instr_ready = 1'b0;
    cyc(15);
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_stall_req: got req=%b, expected 0", imem_req);
    end
    vectors++;
    if ((ack_count - a0) - (pop_count - p0) != 2) begin
      miscompares++;
      $display("FAIL lat_push_per_ack: got acks-pops=%0d, expected 2", (ack_count - a0) - (pop_count - p0));
    end
    vectors++;
    if (ack_count - a0 < 8) begin
      miscompares++;
      $display("FAIL lat_progress: got %0d acks, expected >= 8", ack_count - a0);
    end
  endtask

  task automatic test_backpressure();
    int a0, p0;
    lat_min = 0; lat_max = 0; instr_ready = 1'b0;
    apply_reset();
    a0 = ack_count; p0 = pop_count;
    cyc(10);
    vectors++;
    if (ack_count - a0 != 2 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_fetches: got acks=%0d req=%b, expected 2 0", ack_count - a0, imem_req);
    end
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== RST_PC || instruction !== mem_word(RST_PC)) begin
      miscompares++;
      $display("FAIL bp_hold: got valid=%b pc=%h instr=%h, expected 1 %h %h",
               instr_valid, instr_pc, instruction, RST_PC, mem_word(RST_PC));
    end
    instr_ready = 1'b1;
    cyc(20);
    vectors++;
    if (pop_count - p0 < 15) begin
      miscompares++;
      $display("FAIL bp_resume: got %0d pops, expected >= 15", pop_count - p0);
    end
  endtask

  task automatic test_flush_redirect();
    bit found;
    lat_min = 5; lat_max = 5; instr_ready = 1'b1;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else cyc(1);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL flush_wait_req8: got timeout, expected request at 00000008");
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    cyc(1);
    redirect_valid = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL flush_stale: got req=%b addr=%h, expected 1 00000008", imem_req, imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 32'h100) found = 1'b1;
      else cyc(1);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL flush_refetch: got timeout, expected request at 00000100");
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else cyc(1);
    end
    vectors++;
    if (!found || instr_pc !== 32'h100 || instruction !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL flush_first_pc: got found=%b pc=%h, expected pc=00000100", found, instr_pc);
    end
  endtask

  task automatic test_redirect_ack_pop();
    lat_min = 0; lat_max = 0; instr_ready = 1'b1;
    apply_reset();
    cyc(6);
    vectors++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rap_stream: got valid=%b req=%b, expected 1 1", instr_valid, imem_req);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_2000;
    cyc(1);
    redirect_valid = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      miscompares++;
      $display("FAIL rap_n1: got valid=%b req=%b addr=%h, expected 0 1 00002000",
               instr_valid, imem_req, imem_addr);
    end
    cyc(1);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h2000 || instruction !== mem_word(32'h2000)) begin
      miscompares++;
      $display("FAIL rap_n2: got valid=%b pc=%h instr=%h, expected 1 00002000 %h",
               instr_valid, instr_pc, instruction, mem_word(32'h2000));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [4];
    logic [31:0] got [4];
    int k;
    exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC;
    exp_seq[2] = 32'h0000_0000; exp_seq[3] = 32'h0000_0004;
    lat_min = 0; lat_max = 0; instr_ready = 1'b1;
    apply_reset();
    cyc(3);
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFA;
    cyc(1);
    redirect_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      cyc(1);
      if (instr_valid) begin
        got[k] = instr_pc;
        k++;
      end
    end
    vectors++;
    if (k != 4) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d instructions, expected 4", k);
    end
    for (int i = 0; i < k; i++) begin
      vectors++;
      if (got[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL wrap_pc[%0d]: got %h, expected %h", i, got[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_in_flush();
    lat_min = 6; lat_max = 6; instr_ready = 1'b1;
    apply_reset();
    cyc(2);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    cyc(1);
    redirect_valid = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL rif_flush: got req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RST_PC);
    end
    lat_min = 0; lat_max = 0;
    reset = 1'b1; force_ack = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    force_ack = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rif_restart: got req=%b addr=%h valid=%b, expected 1 %h 0",
               imem_req, imem_addr, instr_valid, RST_PC);
    end
    cyc(1);
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== RST_PC || instruction !== mem_word(RST_PC)) begin
      miscompares++;
      $display("FAIL rif_first: got valid=%b pc=%h instr=%h, expected 1 %h %h",
               instr_valid, instr_pc, instruction, RST_PC, mem_word(RST_PC));
    end
  endtask

  task automatic test_random();
    int p0;
    lat_min = 0; lat_max = 4; noise_en = 1'b1;
    apply_reset();
    p0 = pop_count;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if (i >= 1000 && i < 1012) redirect_valid = 1'b1;
      else redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_target = $urandom;
      cyc(1);
    end
    redirect_valid = 1'b0;
    noise_en       = 1'b0;
    vectors++;
    if (pop_count - p0 <= 100) begin
      miscompares++;
      $display("FAIL random_progress: got %0d pops, expected > 100", pop_count - p0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    instr_ready     = 1'b1;
    test_reset();
    test_latency();
    test_backpressure();
    test_flush_redirect();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_in_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
